// File: rtl/clic_irq_handshake.sv
// rtl/clic_irq_handshake.sv - CLIC interrupt capture, eligibility check and ready/kill handshake
module clic_irq_handshake #(
    parameter int NumSrc     = 256,
    parameter int IdWidth    = $clog2(NumSrc),
    parameter int LevelWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_valid_i,
    input  logic [IdWidth-1:0]    irq_id_i,
    input  logic [LevelWidth-1:0] irq_level_i,
    input  logic [1:0]            irq_priv_i,
    input  logic                  irq_shv_i,
    output logic                  irq_ready_o,
    input  logic                  irq_kill_req_i,
    output logic                  irq_kill_ack_o,
    input  logic [1:0]            cur_priv_i,
    input  logic                  mie_i,
    input  logic                  sie_i,
    input  logic [LevelWidth-1:0] mintthresh_i,
    input  logic [LevelWidth-1:0] sintthresh_i,
    output logic                  req_valid_o,
    output logic [IdWidth-1:0]    req_id_o,
    output logic [LevelWidth-1:0] req_level_o,
    output logic [1:0]            req_priv_o,
    output logic                  req_shv_o,
    input  logic                  core_take_i
);

    localparam logic [1:0] PrivU = 2'b00;
    localparam logic [1:0] PrivS = 2'b01;
    localparam logic [1:0] PrivM = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2,
        KILL    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [IdWidth-1:0]    id_q, id_d;
    logic [LevelWidth-1:0] level_q, level_d;
    logic [1:0]            priv_q, priv_d;
    logic                  shv_q, shv_d;
    logic                  eligible;

    // Eligibility of the captured interrupt against the live privilege, xIE and thresholds.
    always_comb begin
        eligible = 1'b0;
        case (priv_q)
            PrivM: eligible = (cur_priv_i != PrivM) ||
                              (mie_i && (level_q > mintthresh_i));
            PrivS: eligible = (cur_priv_i == PrivU) ||
                              ((cur_priv_i == PrivS) && sie_i && (level_q > sintthresh_i));
            default: eligible = 1'b0;
        endcase
    end

    // State and captured-interrupt registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            level_q <= '0;
            priv_q  <= '0;
            shv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            level_q <= level_d;
            priv_q  <= priv_d;
            shv_q   <= shv_d;
        end
    end

    // Next-state, capture and handshake outputs; the pulses come only from registered state.
    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        level_d        = level_q;
        priv_d         = priv_q;
        shv_d          = shv_q;
        req_valid_o    = 1'b0;
        irq_ready_o    = 1'b0;
        irq_kill_ack_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (irq_valid_i && !irq_kill_req_i) begin
                    id_d    = irq_id_i;
                    level_d = irq_level_i;
                    priv_d  = irq_priv_i;
                    shv_d   = irq_shv_i;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                req_valid_o = eligible;
                // A take only counts while the request is actually offered to the core.
                if (core_take_i && eligible) begin
                    state_d = ACK;
                end else if (irq_kill_req_i) begin
                    state_d = KILL;
                end
            end
            ACK: begin
                irq_ready_o = 1'b1;
                state_d     = IDLE;
            end
            KILL: begin
                irq_kill_ack_o = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_id_o    = id_q;
    assign req_level_o = level_q;
    assign req_priv_o  = priv_q;
    assign req_shv_o   = shv_q;

endmodule

// File: tb/tb_clic_irq_handshake.sv
// tb/tb_clic_irq_handshake.sv - scoreboard bench for clic_irq_handshake
module tb_clic_irq_handshake;

    logic       clk = 1'b0;
    logic       rst;
    logic       irq_valid, irq_shv, irq_kill_req, mie, sie, core_take;
    logic [7:0] irq_id, irq_level, mth, sth;
    logic [1:0] irq_priv, cur_priv;
    logic       irq_ready, irq_kill_ack, req_valid, req_shv;
    logic [7:0] req_id, req_level;
    logic [1:0] req_priv;

    typedef struct packed {
        logic       is_kill;
        logic [7:0] id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    clic_irq_handshake dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .irq_valid_i    (irq_valid),
        .irq_id_i       (irq_id),
        .irq_level_i    (irq_level),
        .irq_priv_i     (irq_priv),
        .irq_shv_i      (irq_shv),
        .irq_ready_o    (irq_ready),
        .irq_kill_req_i (irq_kill_req),
        .irq_kill_ack_o (irq_kill_ack),
        .cur_priv_i     (cur_priv),
        .mie_i          (mie),
        .sie_i          (sie),
        .mintthresh_i   (mth),
        .sintthresh_i   (sth),
        .req_valid_o    (req_valid),
        .req_id_o       (req_id),
        .req_level_o    (req_level),
        .req_priv_o     (req_priv),
        .req_shv_o      (req_shv),
        .core_take_i    (core_take)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ready / kill-ack pulse must match the oldest expected handshake.
    always @(negedge clk) begin
        if (!rst && (irq_ready || irq_kill_ack)) begin
            exp_t e;
            n_cmp++;
            if (irq_ready && irq_kill_ack) begin
                n_err++;
                $display("FAIL both_pulses: ready=1 kill_ack=1 required exclusive at %0t", $time);
            end else if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: ready=%0b kill_ack=%0b required none at %0t",
                         irq_ready, irq_kill_ack, $time);
            end else begin
                e = sb.pop_front();
                if (e.is_kill !== irq_kill_ack || e.id !== req_id) begin
                    n_err++;
                    $display("FAIL handshake: kill=%0b id=%0d required kill=%0b id=%0d at %0t",
                             irq_kill_ack, req_id, e.is_kill, e.id, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; irq_valid = 0; irq_id = 0; irq_level = 0; irq_priv = 0; irq_shv = 0;
        irq_kill_req = 0; cur_priv = 0; mie = 0; sie = 0; mth = 0; sth = 0; core_take = 0;
        #1;
        check("rst_req_valid", req_valid, 0);
        check("rst_ready", irq_ready, 0);
        check("rst_kill_ack", irq_kill_ack, 0);
        check("rst_req_id", req_id, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic M take from U mode
        irq_valid = 1; irq_id = 37; irq_level = 8'h80; irq_priv = 2'b11; irq_shv = 1;
        cur_priv = 2'b00;
        check("idle_no_req", req_valid, 0);
        step();
        check("m_take_valid", req_valid, 1);
        check("m_take_id", req_id, 37);
        check("m_take_level", req_level, 8'h80);
        check("m_take_priv", req_priv, 2'b11);
        check("m_take_shv", req_shv, 1);
        core_take = 1; sb.push_back('{1'b0, 8'd37});
        step();
        check("m_ack_ready", irq_ready, 1);
        check("m_ack_req_valid", req_valid, 0);
        core_take = 0; irq_valid = 0;
        step();
        check("m_ready_one_cycle", irq_ready, 0);

        // Threshold gating in M mode
        cur_priv = 2'b11; mie = 1; mth = 8'h40;
        irq_valid = 1; irq_id = 10; irq_level = 8'h40; irq_priv = 2'b11; irq_shv = 0;
        step();
        check("thr_equal_blocks", req_valid, 0);
        core_take = 1;
        step();
        check("thr_take_ignored", req_valid, 0);
        check("thr_take_no_ready", irq_ready, 0);
        core_take = 0; mth = 8'h3F;
        #1;
        check("thr_lower_same_cycle", req_valid, 1);
        core_take = 1; sb.push_back('{1'b0, 8'd10});
        step();
        check("thr_ack_ready", irq_ready, 1);
        core_take = 0; irq_valid = 0;
        step();

        // Kill then new capture
        cur_priv = 2'b00; irq_valid = 1; irq_id = 5; irq_level = 8'h10; irq_priv = 2'b11;
        step();
        check("kill_pending_id", req_id, 5);
        irq_kill_req = 1; sb.push_back('{1'b1, 8'd5});
        step();
        check("kill_ack", irq_kill_ack, 1);
        check("kill_no_ready", irq_ready, 0);
        check("kill_req_valid", req_valid, 0);
        irq_kill_req = 0; irq_id = 6;
        step();
        check("kill_ack_one_cycle", irq_kill_ack, 0);
        step();
        check("recapture_id", req_id, 6);
        check("recapture_valid", req_valid, 1);

        // Simultaneous take and kill: take wins
        core_take = 1; irq_kill_req = 1; sb.push_back('{1'b0, 8'd6});
        step();
        check("tk_ready", irq_ready, 1);
        check("tk_no_kill_ack", irq_kill_ack, 0);
        core_take = 0; irq_kill_req = 0; irq_valid = 0;
        step();

        // S-mode target
        cur_priv = 2'b11; sie = 0; sth = 8'hFF;
        irq_valid = 1; irq_id = 20; irq_level = 8'hFF; irq_priv = 2'b01;
        step();
        for (int i = 0; i < 4; i++) begin
            check("s_from_m_blocked", req_valid, 0);
            step();
        end
        cur_priv = 2'b00;
        #1;
        check("s_from_u_eligible", req_valid, 1);
        cur_priv = 2'b01; sie = 1;
        #1;
        check("s_thresh_ff_blocks", req_valid, 0);
        sth = 8'hFE;
        #1;
        check("s_level_above", req_valid, 1);
        sie = 0;
        #1;
        check("s_sie_clear", req_valid, 0);
        irq_kill_req = 1; sb.push_back('{1'b1, 8'd20});
        step();
        irq_kill_req = 0; irq_valid = 0;
        step();

        // Reserved privilege never eligible
        cur_priv = 2'b00; irq_valid = 1; irq_id = 9; irq_priv = 2'b10;
        step();
        check("reserved_priv", req_valid, 0);
        irq_kill_req = 1; sb.push_back('{1'b1, 8'd9});
        step();
        irq_kill_req = 0; irq_valid = 0;
        step();

        // Asynchronous reset in PENDING and in ACK
        irq_valid = 1; irq_id = 44; irq_level = 8'h22; irq_priv = 2'b11;
        step();
        check("pre_rst_valid", req_valid, 1);
        #2 rst = 1;
        #1;
        check("rst_pend_req_valid", req_valid, 0);
        check("rst_pend_req_id", req_id, 0);
        rst = 0;
        step();
        check("rst_recapture_valid", req_valid, 1);
        check("rst_recapture_id", req_id, 44);
        core_take = 1;
        step();
        check("rst_pre_ack_ready", irq_ready, 1);
        #2 rst = 1;
        #1;
        check("rst_ack_ready", irq_ready, 0);
        check("rst_ack_req_id", req_id, 0);
        core_take = 0; rst = 0;
        step();
        check("rst_ack_recapture", req_id, 44);
        irq_kill_req = 1; sb.push_back('{1'b1, 8'd44});
        step();
        irq_kill_req = 0; irq_valid = 0;
        step();
        step();

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clic_irq_handshake.md
Name: clic_irq_handshake

Overview:
- Sits between the external CLIC and the CVA6 controller/CSR trap logic when RVSCLIC is enabled.
- Captures the CLIC's selected interrupt (id, level, privilege, SHV) and holds it stable.
- Decides eligibility against the current privilege, xIE and xintthresh, and presents a single request to the core.
- Completes the CLIC ready/kill handshake once the core takes the trap or the CLIC withdraws the request.

Parameters:
- NumSrc, 256, number of CLIC interrupt sources.
- IdWidth, $clog2(NumSrc) (8), width of interrupt id.
- LevelWidth, 8, interrupt level / threshold width.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-high
- irq_valid_i  in  1  CLIC request valid; held until ready or kill-ack
- irq_id_i  in  IdWidth  CLIC interrupt id
- irq_level_i  in  LevelWidth  interrupt level
- irq_priv_i  in  2  target privilege (2'b11=M, 2'b01=S)
- irq_shv_i  in  1  selective hardware vectoring
- irq_ready_o  out  1  one-cycle accept pulse to CLIC
- irq_kill_req_i  in  1  CLIC requests withdrawal of pending irq
- irq_kill_ack_o  out  1  one-cycle withdrawal acknowledge
- cur_priv_i  in  2  current hart privilege
- mie_i  in  1  mstatus.MIE
- sie_i  in  1  mstatus.SIE
- mintthresh_i  in  LevelWidth  M-mode threshold
- sintthresh_i  in  LevelWidth  S-mode threshold
- req_valid_o  out  1  eligible interrupt pending to core
- req_id_o  out  IdWidth  captured id
- req_level_o  out  LevelWidth  captured level
- req_priv_o  out  2  captured privilege
- req_shv_o  out  1  captured SHV
- core_take_i  in  1  core commits the interrupt trap this cycle

Behaviour:
- FSM states: IDLE, PENDING, ACK, KILL. Reset (async, any state) -> IDLE.
- Reset values: all outputs 0; captured registers 0.
- IDLE:
  - irq_valid_i=1 and irq_kill_req_i=0 -> capture id/level/priv/shv, go to PENDING. First req_valid_o possible the next cycle (1-cycle latency).
  - irq_valid_i=1 with irq_kill_req_i=1 -> no capture, stay in IDLE.
- PENDING:
  - Captured fields drive req_*_o unchanged.
  - req_valid_o is combinational from captured state and current CSR inputs. It is 1 iff eligible:
    - priv M: cur_priv_i<M, or (cur_priv_i==M and mie_i and level>mintthresh_i).
    - priv S: cur_priv_i==U, or (cur_priv_i==S and sie_i and level>sintthresh_i). cur_priv_i==M -> ineligible.
  - Level compare is unsigned, strict greater-than. Threshold 0xFF blocks every level.
  - Reserved priv values (2'b00, 2'b10) -> never eligible.
  - core_take_i is honoured only while req_valid_o=1; otherwise ignored.
  - core_take_i=1 (qualified) -> ACK. Takes priority over a simultaneous irq_kill_req_i.
  - Else irq_kill_req_i=1 -> KILL.
  - Else stay in PENDING; eligibility re-evaluates every cycle as the CSRs change.
- ACK:
  - irq_ready_o=1 for exactly one cycle; req_valid_o=0.
  - Then IDLE. The CLIC deasserts valid/kill after seeing ready.
  - The IDLE entered after ACK may capture a new request in its first cycle.
- KILL:
  - irq_kill_ack_o=1 for exactly one cycle; req_valid_o=0.
  - Then IDLE.
- irq_ready_o and irq_kill_ack_o are never high in the same cycle; each is driven only from its own state.
- Changes to irq_*_i fields while in PENDING are ignored. The CLIC must use kill to replace a request.
- No combinational path exists from irq_valid_i to irq_ready_o.

Test Plan:
- Basic M take: cur_priv=U; valid, id=37, level=0x80, priv=M.
  - Required: req_valid_o=1 at cycle+1 with req_id_o=37.
  - core_take_i=1 -> irq_ready_o pulses one cycle later, then IDLE.
- Threshold gating: cur_priv=M, mie=1, level=0x40, mintthresh=0x40.
  - Required: req_valid_o=0.
  - Drop mintthresh to 0x3F -> req_valid_o=1 the same cycle.
  - core_take_i asserted while req_valid_o=0 -> no state change.
- Kill: PENDING with id=5.
  - irq_kill_req_i=1 -> irq_kill_ack_o=1 next cycle for one cycle, irq_ready_o stays 0.
  - Then new valid id=6 is captured.
- Simultaneous take+kill in PENDING: required irq_ready_o pulse, irq_kill_ack_o=0.
- S-mode privilege: priv=S, cur_priv=M -> req_valid_o=0 indefinitely. cur_priv=U -> req_valid_o=1 regardless of sie/threshold.
- Reset mid-operation: assert rst_i asynchronously in PENDING and again in ACK.
  - All outputs 0 immediately; state IDLE.
  - After release, a held irq_valid_i is recaptured.
